// File: rtl/sys_bench_pkg.sv
// Shared types and helpers for the sys_bench run controller.
// Optional parity support is enabled by defining SYS_BENCH_PARITY_EN.
package sys_bench_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      SEQ_PRE,
      SEQ_RST,
      SEQ_RUN,
      SEQ_DONE
   } seq_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   // Width needed to index n entries, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sys_bench_fifo.sv
// Synchronous FIFO with a registered head word; the head holds its last
// value when the FIFO drains. Push while full is accepted only with a pop.
module sys_bench_fifo
   import sys_bench_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = clog2_min1(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [W-1:0]  head_q, head_d;
   logic          do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = head_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      head_d   = head_q;
      // A word written into an otherwise-empty FIFO bypasses the array.
      if (do_push && ((cnt_q - (AW+1)'(do_pop)) == '0)) begin
         head_d = wdata;
      end else if (cnt_d != '0) begin
         head_d = mem[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/sys_bench_ctrl.sv
// Run controller: DUT reset sequencing, cycle watchdog and UART TX capture.
// Define SYS_BENCH_PARITY_EN to receive and check one even-parity bit.
module sys_bench_ctrl
   import sys_bench_pkg::*;
#(
   parameter int RST_DELAY    = 4,
   parameter int RST_WIDTH    = 4,
   parameter int MAX_CYCLES   = 15000,
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 sys_rst,
   input  logic                 uart_line,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [CNT_W-1:0]     rx_count,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overflow,
   output logic                 running,
   output logic                 timeout
);

   localparam int BW = clog2_min1(CLKS_PER_BIT);
   localparam int IW = clog2_min1(DATA_BITS);
   localparam logic [BW-1:0] HALF_M1  = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] FULL_M1  = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

   seq_state_e seq_q, seq_d;
   logic [31:0] seq_cnt_q, seq_cnt_d;

   always_comb begin
      seq_d     = seq_q;
      seq_cnt_d = seq_cnt_q + 32'd1;
      case (seq_q)
         SEQ_PRE: if (seq_cnt_q == 32'(RST_DELAY - 1)) begin
            seq_d     = SEQ_RST;
            seq_cnt_d = '0;
         end
         SEQ_RST: if (seq_cnt_q == 32'(RST_WIDTH - 1)) begin
            seq_d     = SEQ_RUN;
            seq_cnt_d = '0;
         end
         SEQ_RUN: if (seq_cnt_q == 32'(MAX_CYCLES - 1)) begin
            seq_d     = SEQ_DONE;
            seq_cnt_d = '0;
         end
         SEQ_DONE: seq_cnt_d = seq_cnt_q;
         default: begin
            seq_d     = SEQ_PRE;
            seq_cnt_d = '0;
         end
      endcase
   end

   assign sys_rst = (seq_q == SEQ_RST);
   assign running = (seq_q == SEQ_RUN);
   assign timeout = (seq_q == SEQ_DONE);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;
   logic       line_s;

   assign sync_d = {sync_q[0], uart_line};
   assign line_s = sync_q[1];
   assign prev_d = line_s;

   rx_state_e            rx_q, rx_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [IW-1:0]        bidx_q, bidx_d;
   logic [DATA_BITS-1:0] shr_q, shr_d;
   logic                 fe_q, fe_d;
   logic                 push;
`ifdef SYS_BENCH_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 pe_q, pe_d;
`endif

   always_comb begin
      rx_d   = rx_q;
      bcnt_d = bcnt_q + BW'(1);
      bidx_d = bidx_q;
      shr_d  = shr_q;
      fe_d   = 1'b0;
      push   = 1'b0;
`ifdef SYS_BENCH_PARITY_EN
      par_bad_d = par_bad_q;
      pe_d      = 1'b0;
`endif
      case (rx_q)
         // After a bad stop bit the line is still low, so no edge is seen
         // here until it has returned high.
         RX_IDLE: begin
            bcnt_d = '0;
            if (!line_s && prev_q) rx_d = RX_START;
         end
         RX_START: if (bcnt_q == HALF_M1) begin
            bcnt_d = '0;
            bidx_d = '0;
            rx_d   = line_s ? RX_IDLE : RX_DATA;
`ifdef SYS_BENCH_PARITY_EN
            par_bad_d = 1'b0;
`endif
         end
         RX_DATA: if (bcnt_q == FULL_M1) begin
            bcnt_d = '0;
            shr_d  = {line_s, shr_q[DATA_BITS-1:1]};
            bidx_d = bidx_q + IW'(1);
            if (bidx_q == IDX_LAST) begin
`ifdef SYS_BENCH_PARITY_EN
               rx_d = RX_PARITY;
`else
               rx_d = RX_STOP;
`endif
            end
         end
`ifdef SYS_BENCH_PARITY_EN
         RX_PARITY: if (bcnt_q == FULL_M1) begin
            bcnt_d    = '0;
            par_bad_d = line_s ^ (^shr_q);
            rx_d      = RX_STOP;
         end
`endif
         RX_STOP: if (bcnt_q == FULL_M1) begin
            rx_d = RX_IDLE;
            if (!line_s) fe_d = 1'b1;
`ifdef SYS_BENCH_PARITY_EN
            else if (par_bad_q) pe_d = 1'b1;
`endif
            else push = 1'b1;
         end
         default: rx_d = RX_IDLE;
      endcase
      if (!running) begin
         rx_d = RX_IDLE;
         fe_d = 1'b0;
         push = 1'b0;
`ifdef SYS_BENCH_PARITY_EN
         pe_d = 1'b0;
`endif
      end
   end

   logic             fifo_full, fifo_empty, pop, accept;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   assign rx_valid = !fifo_empty;
   assign pop      = rx_valid && rx_ready;
   assign accept   = push && (!fifo_full || pop);

   always_comb begin
      cnt_d = cnt_q;
      if (accept && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      ovf_d = ovf_q | (push && !accept);
   end

   sys_bench_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (shr_q),
      .pop   (pop),
      .rdata (rx_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rx_count  = cnt_q;
   assign overflow  = ovf_q;
   assign frame_err = fe_q;
`ifdef SYS_BENCH_PARITY_EN
   assign parity_err = pe_q;
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_q     <= SEQ_PRE;
         seq_cnt_q <= '0;
         sync_q    <= 2'b11;
         prev_q    <= 1'b1;
         rx_q      <= RX_IDLE;
         bcnt_q    <= '0;
         bidx_q    <= '0;
         shr_q     <= '0;
         fe_q      <= 1'b0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
`ifdef SYS_BENCH_PARITY_EN
         par_bad_q <= 1'b0;
         pe_q      <= 1'b0;
`endif
      end else begin
         seq_q     <= seq_d;
         seq_cnt_q <= seq_cnt_d;
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         rx_q      <= rx_d;
         bcnt_q    <= bcnt_d;
         bidx_q    <= bidx_d;
         shr_q     <= shr_d;
         fe_q      <= fe_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
`ifdef SYS_BENCH_PARITY_EN
         par_bad_q <= par_bad_d;
         pe_q      <= pe_d;
`endif
      end
   end

endmodule

// File: tb/tb_sys_bench_ctrl.sv
// Directed bench for sys_bench_ctrl: reset sequencing, watchdog, UART
// capture, framing/glitch handling, FIFO boundaries and mid-frame reset.
module tb_sys_bench_ctrl;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_line;
   logic        rx_ready;

   logic        sys_rst, rx_valid, frame_err, parity_err, overflow, running, timeout;
   logic [7:0]  rx_data;
   logic [15:0] rx_count;

   logic        t_sys_rst, t_rx_valid, t_frame_err, t_parity_err, t_overflow, t_running, t_timeout;
   logic [7:0]  t_rx_data;
   logic [15:0] t_rx_count;

   always #5 clk = ~clk;

   sys_bench_ctrl #(.MAX_CYCLES(30000)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .sys_rst    (sys_rst),
      .uart_line  (uart_line),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_count   (rx_count),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overflow   (overflow),
      .running    (running),
      .timeout    (timeout)
   );

   // Short watchdog instance used only for the sequencing/timeout checks.
   sys_bench_ctrl #(.MAX_CYCLES(50)) u_dut_to (
      .clk        (clk),
      .rst        (rst),
      .sys_rst    (t_sys_rst),
      .uart_line  (1'b1),
      .rx_data    (t_rx_data),
      .rx_valid   (t_rx_valid),
      .rx_ready   (1'b0),
      .rx_count   (t_rx_count),
      .frame_err  (t_frame_err),
      .parity_err (t_parity_err),
      .overflow   (t_overflow),
      .running    (t_running),
      .timeout    (t_timeout)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   // Observed traffic, accumulated for the whole run.
   logic [7:0] got[$];
   int n_vld = 0;
   int n_fe  = 0;
   int n_pe  = 0;

   always @(negedge clk) begin
      if (rx_valid) n_vld++;
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) n_fe++;
      if (parity_err) n_pe++;
   end

   task automatic drive_bit(input logic b);
      uart_line = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // One frame; pop_at_stop pulses rx_ready on the cycle the byte is pushed.
   task automatic send_byte(input logic [7:0] d, input logic stop_b,
                            input logic par_ok, input logic pop_at_stop);
      @(posedge clk); #1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef SYS_BENCH_PARITY_EN
      drive_bit((^d) ^ ~par_ok);
`endif
      uart_line = stop_b;
      for (int j = 0; j < CPB; j++) begin
         if (pop_at_stop && j == 10) rx_ready = 1'b1;
         if (pop_at_stop && j == 11) rx_ready = 1'b0;
         @(posedge clk); #1;
      end
      uart_line = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pop_n(input int n);
      @(posedge clk); #1;
      rx_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      rx_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "tb watchdog");
   end

   initial begin
      int lo, hi, nrun, guard, b0, v0, f0, p0;
      rst = 1'b1; uart_line = 1'b1; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_sys_rst", sys_rst, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_count", rx_count, 0);
      chk("rst_flags", {frame_err, parity_err, overflow, running, timeout}, 0);

      // Reset sequencing and watchdog.
      @(posedge clk); #1;
      rst = 1'b0;
      lo = 0; hi = 0; guard = 0;
      @(negedge clk);
      while (!t_running && guard < 40) begin
         if (t_sys_rst) hi++;
         else if (hi == 0) lo++;
         guard++;
         @(negedge clk);
      end
      chk("pre_low_cycles", lo, 4);
      chk("rst_high_cycles", hi, 4);
      chk("running_up", t_running, 1);
      chk("main_running_up", running, 1);
      nrun = 0; guard = 0;
      while (!t_timeout && guard < 200) begin
         if (t_running) nrun++;
         guard++;
         @(negedge clk);
      end
      chk("run_to_timeout", nrun, 50);
      repeat (5) @(negedge clk);
      chk("timeout_sticky", {t_timeout, t_running, t_sys_rst}, 3'b100);

      // Two good bytes with the consumer always ready.
      rx_ready = 1'b1;
      b0 = got.size(); v0 = n_vld; f0 = n_fe; p0 = n_pe;
      send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("two_bytes_n", got.size() - b0, 2);
      chk("byte0", got[b0], 8'hA5);
      chk("byte1", got[b0+1], 8'h3C);
      chk("valid_cycles", n_vld - v0, 2);
      chk("rx_count_2", rx_count, 2);
      chk("rx_data_hold", rx_data, 8'h3C);
      chk("rx_valid_empty", rx_valid, 0);
      chk("no_err_good", (n_fe - f0) + (n_pe - p0), 0);

      // Bad stop bit, then a short low glitch.
      send_byte(8'h55, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("frame_err_pulse", n_fe - f0, 1);
      chk("fe_no_byte", got.size() - b0, 2);
      chk("fe_rx_count", rx_count, 2);
      @(posedge clk); #1;
      uart_line = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      uart_line = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("glitch_no_byte", got.size() - b0, 2);
      chk("glitch_no_err", n_fe - f0, 1);
      chk("glitch_rx_valid", rx_valid, 0);

      // Overflow: nine bytes into an eight-deep FIFO.
      rx_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_byte(8'(16 + i), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("ovf_flag", overflow, 1);
      chk("ovf_rx_count", rx_count, 10);
      chk("ovf_head", rx_data, 8'h10);
      b0 = got.size();
      pop_n(8);
      @(negedge clk);
      chk("ovf_pop_n", got.size() - b0, 8);
      for (int i = 0; i < 8; i++) chk("ovf_pop_order", got[b0+i], 32'(16 + i));
      chk("ovf_drained", rx_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // Reset in the middle of a frame.
      @(posedge clk); #1;
      uart_line = 1'b0;
      repeat (CPB * 4) @(posedge clk);
      #1;
      rst = 1'b1; uart_line = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_data", rx_data, 0);
      chk("mid_rst_count", rx_count, 0);
      chk("mid_rst_flags", {sys_rst, rx_valid, frame_err, parity_err, overflow, running, timeout}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      guard = 0;
      while (!running && guard < 40) begin
         guard++;
         @(negedge clk);
      end
      chk("rerun", running, 1);
      rx_ready = 1'b1;
      b0 = got.size(); f0 = n_fe;
      send_byte(8'h5A, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("post_rst_n", got.size() - b0, 1);
      chk("post_rst_byte", got[b0], 8'h5A);
      chk("post_rst_count", rx_count, 1);
      chk("post_rst_no_fe", n_fe - f0, 0);

      // Full FIFO with push and pop on the same cycle.
      rx_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_byte(8'(32 + i), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("full_count", rx_count, 9);
      chk("full_no_ovf", overflow, 0);
      b0 = got.size();
      send_byte(8'h28, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("pp_no_ovf", overflow, 0);
      chk("pp_count", rx_count, 10);
      chk("pp_popped", got[b0], 8'h20);
      chk("pp_head", rx_data, 8'h21);
      pop_n(8);
      @(negedge clk);
      chk("pp_drain_n", got.size() - b0, 9);
      for (int i = 1; i < 9; i++) chk("pp_drain_order", got[b0+i], 32'(32 + i));
      chk("pp_empty", rx_valid, 0);

`ifdef SYS_BENCH_PARITY_EN
      rx_ready = 1'b1;
      b0 = got.size(); p0 = n_pe;
      send_byte(8'h07, 1'b1, 1'b1, 1'b0);
      send_byte(8'h07, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("par_n", got.size() - b0, 1);
      chk("par_byte", got[b0], 8'h07);
      chk("par_err_pulse", n_pe - p0, 1);
      chk("par_count", rx_count, 11);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
